// File: rtl/coeff_byte_encoder.sv
// coeff_byte_encoder: streaming ByteEncode_d stage.
// Packs N_COEFFS coefficients of D bits each, LSB first, into a continuous
// bit string and emits it as bytes over a valid/ready stream. Global bit i
// lands in byte i/8 at bit position i%8.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin a polynomial (honoured only in IDLE)
//   coeff_valid/ready  coefficient input handshake, coeff_data[D-1:0]
//   byte_valid/ready   byte output handshake, byte_data[7:0]
//   byte_last          qualifies the final byte of the polynomial
//   busy               high while a polynomial is in progress
//   done               one-cycle pulse after the final byte handshake
module coeff_byte_encoder #(
    parameter int unsigned D        = 12,
    parameter int unsigned N_COEFFS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         coeff_valid,
    input  logic [D-1:0] coeff_data,
    output logic         coeff_ready,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    output logic         byte_last,
    input  logic         byte_ready,
    output logic         busy,
    output logic         done
);

    localparam int unsigned ACC_W   = D + 7;
    localparam int unsigned BC_W    = $clog2(D + 8);
    localparam int unsigned N_BYTES = N_COEFFS * D / 8;
    localparam int unsigned CC_W    = $clog2(N_COEFFS + 1);
    localparam int unsigned BY_W    = $clog2(N_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [CC_W-1:0]   coeff_cnt_q;
    logic [BY_W-1:0]   byte_cnt_q;
    logic              byte_valid_q;
    logic [7:0]        byte_data_q;
    logic              byte_last_q;

    logic accept;
    logic drain;
    logic extract;

    // Handshake decode; coeff_ready depends on registers only.
    assign coeff_ready = (state_q == RUN) && (bit_cnt_q < BC_W'(8)) &&
                         (coeff_cnt_q < CC_W'(N_COEFFS));
    assign accept      = coeff_valid && coeff_ready;
    assign drain       = byte_valid_q && byte_ready;
    // Extraction needs a full byte and an output register that is free or emptying now.
    assign extract     = (state_q == RUN) && (bit_cnt_q >= BC_W'(8)) &&
                         (!byte_valid_q || byte_ready);

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_last   = byte_last_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

    // FSM, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            coeff_cnt_q  <= '0;
            byte_cnt_q   <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= RUN;
                        acc_q        <= '0;
                        bit_cnt_q    <= '0;
                        coeff_cnt_q  <= '0;
                        byte_cnt_q   <= '0;
                        byte_valid_q <= 1'b0;
                        byte_data_q  <= 8'h00;
                        byte_last_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // accept and extract never coincide: bit_cnt<8 versus bit_cnt>=8
                    if (accept) begin
                        acc_q       <= acc_q | (ACC_W'(coeff_data) << bit_cnt_q);
                        bit_cnt_q   <= bit_cnt_q + BC_W'(D);
                        coeff_cnt_q <= coeff_cnt_q + CC_W'(1);
                    end
                    if (extract) begin
                        byte_valid_q <= 1'b1;
                        byte_data_q  <= acc_q[7:0];
                        byte_last_q  <= (byte_cnt_q == BY_W'(N_BYTES - 1));
                        acc_q        <= acc_q >> 8;
                        bit_cnt_q    <= bit_cnt_q - BC_W'(8);
                        byte_cnt_q   <= byte_cnt_q + BY_W'(1);
                    end else if (drain) begin
                        byte_valid_q <= 1'b0;
                    end
                    // N_COEFFS*D is a whole number of bytes, so nothing is left after the last byte.
                    if (drain && byte_last_q) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_byte_encoder.sv
// Bench for coeff_byte_encoder: several parameterisations share one stimulus
// driver; sel chooses which instance is driven and observed. Expected bytes
// come from a bit-level packing model of the coefficient list.
module tb_coeff_byte_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        coeff_valid;
    logic [11:0] coeff_data;
    logic        byte_ready;
    logic [2:0]  sel;

    logic [4:0]  st_v, cv_v;
    logic [4:0]  cr_a, bv_a, bl_a, bsy_a, dn_a;
    logic [7:0]  bd_a [5];

    int vectors     = 0;
    int miscompares = 0;

    assign st_v = start       ? (5'b00001 << sel) : 5'b00000;
    assign cv_v = coeff_valid ? (5'b00001 << sel) : 5'b00000;

    coeff_byte_encoder #(.D(12), .N_COEFFS(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st_v[0]), .coeff_valid(cv_v[0]),
        .coeff_data(coeff_data[11:0]), .coeff_ready(cr_a[0]), .byte_valid(bv_a[0]),
        .byte_data(bd_a[0]), .byte_last(bl_a[0]), .byte_ready(byte_ready),
        .busy(bsy_a[0]), .done(dn_a[0]));

    coeff_byte_encoder #(.D(1), .N_COEFFS(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st_v[1]), .coeff_valid(cv_v[1]),
        .coeff_data(coeff_data[0:0]), .coeff_ready(cr_a[1]), .byte_valid(bv_a[1]),
        .byte_data(bd_a[1]), .byte_last(bl_a[1]), .byte_ready(byte_ready),
        .busy(bsy_a[1]), .done(dn_a[1]));

    coeff_byte_encoder #(.D(4), .N_COEFFS(256)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st_v[2]), .coeff_valid(cv_v[2]),
        .coeff_data(coeff_data[3:0]), .coeff_ready(cr_a[2]), .byte_valid(bv_a[2]),
        .byte_data(bd_a[2]), .byte_last(bl_a[2]), .byte_ready(byte_ready),
        .busy(bsy_a[2]), .done(dn_a[2]));

    coeff_byte_encoder #(.D(12), .N_COEFFS(256)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st_v[3]), .coeff_valid(cv_v[3]),
        .coeff_data(coeff_data[11:0]), .coeff_ready(cr_a[3]), .byte_valid(bv_a[3]),
        .byte_data(bd_a[3]), .byte_last(bl_a[3]), .byte_ready(byte_ready),
        .busy(bsy_a[3]), .done(dn_a[3]));

    coeff_byte_encoder #(.D(7), .N_COEFFS(8)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st_v[4]), .coeff_valid(cv_v[4]),
        .coeff_data(coeff_data[6:0]), .coeff_ready(cr_a[4]), .byte_valid(bv_a[4]),
        .byte_data(bd_a[4]), .byte_last(bl_a[4]), .byte_ready(byte_ready),
        .busy(bsy_a[4]), .done(dn_a[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packing: bit i of the stream is bit i%d of coefficient i/d.
    task automatic pack_model(input int d, input int c[$], output int b[$]);
        int nbits;
        nbits = c.size() * d;
        b = {};
        for (int i = 0; i < nbits / 8; i++) b.push_back(0);
        for (int i = 0; i < nbits; i++)
            if (((c[i / d] >> (i % d)) & 1) != 0) b[i / 8] = b[i / 8] | (1 << (i % 8));
    endtask

    task automatic chk_reset_values(input int s);
        chk("rst_coeff_ready", 32'(cr_a[s]), 0);
        chk("rst_byte_valid", 32'(bv_a[s]), 0);
        chk("rst_byte_data", 32'(bd_a[s]), 0);
        chk("rst_byte_last", 32'(bl_a[s]), 0);
        chk("rst_busy", 32'(bsy_a[s]), 0);
        chk("rst_done", 32'(dn_a[s]), 0);
    endtask

    // mode 0: always ready; 1: random ready/valid; 2: hold ready low 10 cycles after first byte.
    task automatic run_poly(input int s, input int d, input int c[$], input int mode,
                            input int abort_bytes, input int pulse_at);
        int exp_b[$];
        int n, nb, k, j, cyc, budget, first_bv, first_acc, last_acc, acc_cnt;
        logic prev_stall;
        logic [7:0] pd;
        logic pl;
        n = c.size();
        pack_model(d, c, exp_b);
        nb = exp_b.size();
        budget = 10 * n + 100;
        @(negedge clk);
        sel = 3'(s); start = 1'b1; coeff_valid = 1'b0; byte_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(bsy_a[s]), 1);
        chk("start_coeff_ready", 32'(cr_a[s]), 1);
        k = 0; j = 0; cyc = 0; first_bv = -1; first_acc = -1; last_acc = -1; acc_cnt = 0;
        prev_stall = 1'b0; pd = 8'h00; pl = 1'b0;
        while (cyc < budget) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(bv_a[s]), 1);
                chk("stall_data", 32'(bd_a[s]), 32'(pd));
                chk("stall_last", 32'(bl_a[s]), 32'(pl));
            end
            if (mode == 2 && first_bv >= 0 && cyc - first_bv >= 1 && cyc - first_bv <= 9) begin
                chk("hold_coeff_ready", 32'(cr_a[s]), 0);
                chk("hold_byte_data", 32'(bd_a[s]), 32'(exp_b[0]));
            end
            if (first_bv < 0 && bv_a[s]) first_bv = cyc;
            case (mode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = 1'($urandom_range(0, 1));
                default: byte_ready = !(first_bv >= 0 && cyc - first_bv < 10);
            endcase
            start = (cyc == pulse_at);
            coeff_valid = (k < n) && (mode != 1 || $urandom_range(0, 3) != 0);
            coeff_data = coeff_valid ? 12'(c[k]) : 12'($urandom);
            if (coeff_valid && cr_a[s]) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
                k++;
            end
            if (bv_a[s] && byte_ready) begin
                chk($sformatf("byte%0d_data", j), 32'(bd_a[s]), 32'(exp_b[j]));
                chk($sformatf("byte%0d_last", j), 32'(bl_a[s]), 32'(j == nb - 1));
                j++;
            end
            prev_stall = bv_a[s] && !byte_ready;
            pd = bd_a[s];
            pl = bl_a[s];
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (j == nb || (abort_bytes > 0 && j == abort_bytes)) break;
        end
        coeff_valid = 1'b0;
        byte_ready = 1'b0;
        if (j < nb && !(abort_bytes > 0 && j == abort_bytes)) begin
            chk("timeout_bytes", 32'(j), 32'(nb));
            return;
        end
        if (abort_bytes > 0 && j == abort_bytes) begin
            chk("abort_busy", 32'(bsy_a[s]), 1);
            rst_n = 1'b0;
            #1;
            chk_reset_values(s);
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        chk("done_pulse", 32'(dn_a[s]), 1);
        chk("done_busy", 32'(bsy_a[s]), 0);
        chk("accept_count", 32'(acc_cnt), 32'(n));
        if (s == 0) chk("first_byte_latency", 32'(first_bv - first_acc), 2);
        if (s == 1) chk("contiguous_accepts", 32'(last_acc - first_acc + 1), 8);
        @(negedge clk);
        chk("done_cleared", 32'(dn_a[s]), 0);
        chk("idle_busy", 32'(bsy_a[s]), 0);
        chk("idle_byte_valid", 32'(bv_a[s]), 0);
        chk("idle_coeff_ready", 32'(cr_a[s]), 0);
    endtask

    initial begin
        int c[$];
        rst_n = 1'b0; start = 1'b0; coeff_valid = 1'b0; coeff_data = '0;
        byte_ready = 1'b0; sel = 3'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 5; s++) chk_reset_values(s);
        rst_n = 1'b1;
        @(negedge clk);

        c = '{12'hABC, 12'h123};
        run_poly(0, 12, c, 0, 0, -1);

        c = '{1, 0, 1, 1, 0, 0, 0, 1};
        run_poly(1, 1, c, 0, 0, -1);

        c = {};
        for (int i = 0; i < 256; i++) c.push_back(i % 16);
        run_poly(2, 4, c, 1, 0, -1);

        c = {};
        for (int i = 0; i < 256; i++) c.push_back(int'($urandom_range(0, 4095)));
        run_poly(3, 12, c, 2, 0, -1);

        c = {};
        for (int i = 0; i < 256; i++) c.push_back(int'($urandom_range(0, 4095)));
        run_poly(3, 12, c, 0, 40, 20);

        run_poly(3, 12, c, 1, 0, -1);

        for (int r = 0; r < 3; r++) begin
            c = {};
            for (int i = 0; i < 8; i++) c.push_back(int'($urandom_range(0, 127)));
            run_poly(4, 7, c, 1, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
